// File: rtl/leading_one_pipe.sv
// leading_one_pipe: pipelined leading-one detector with valid/ready flow control.
// For each accepted word it reports the one-hot mask of the highest set bit,
// that bit's index, a zero flag and the word with the leading one cleared.
// Detection is combinational in front of stage 0; stages 1..STAGES-1 only
// delay the fields. The last stage drives the outputs directly.
//
// Optional build macro: LEADING_ONE_PIPE_NORM_EN
//   When defined, an extra output out_norm carries the word shifted left so
//   its leading one sits at bit WIDTH-1 (0 for a zero word). It travels with
//   the other fields through the pipe.

module leading_one_pipe #(
  parameter  int WIDTH  = 16,
  parameter  int STAGES = 2,
  localparam int POSW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [POSW-1:0]  out_pos,
  output logic             out_zero,
`ifdef LEADING_ONE_PIPE_NORM_EN
  output logic [WIDTH-1:0] out_norm,
`endif
  output logic [WIDTH-1:0] out_rem
);

  // ---------------------------------------------------------------------------
  // Combinational detection on the incoming word
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] det_onehot;
  logic [POSW-1:0]  det_pos;
  logic             det_zero;
  logic [WIDTH-1:0] det_rem;
`ifdef LEADING_ONE_PIPE_NORM_EN
  logic [WIDTH-1:0] det_norm;
`endif

  // Priority scan from the LSB upward: the last set bit seen is the highest,
  // so the final assignment wins and bit WIDTH-1 has top priority.
  always_comb begin
    det_pos  = '0;
    det_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_data[i]) begin
        det_pos  = POSW'(i);
        det_zero = 1'b0;
      end
    end
  end

  // Mask and residual follow from the index; a zero word yields an empty mask,
  // which also makes the residual zero because the word itself is zero.
  always_comb begin
    det_onehot = '0;
    if (!det_zero) begin
      det_onehot = WIDTH'(1) << det_pos;
    end
    det_rem = in_data ^ det_onehot;
  end

`ifdef LEADING_ONE_PIPE_NORM_EN
  // Normalise so the leading one lands on the MSB. WIDTH-1 always fits in
  // POSW bits, and a zero word shifts to zero regardless of the amount.
  always_comb begin
    det_norm = in_data << (POSW'(WIDTH - 1) - det_pos);
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage valid bits and the combinational ready chain
  // ---------------------------------------------------------------------------
  // A stage may load when it is empty or when everything downstream of it
  // can move. Written in closed form (any empty stage at or after k, or the
  // sink ready) so en has no dependency on itself.
  logic [STAGES-1:0] v_vec;
  logic [STAGES-1:0] en;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             v_reg;
      logic [WIDTH-1:0] onehot_reg;
      logic [POSW-1:0]  pos_reg;
      logic             zero_reg;
      logic [WIDTH-1:0] rem_reg;
`ifdef LEADING_ONE_PIPE_NORM_EN
      logic [WIDTH-1:0] norm_reg;
`endif

      // Source of this stage: the detector for stage 0, the previous stage
      // otherwise.
      logic             v_in;
      logic [WIDTH-1:0] onehot_in;
      logic [POSW-1:0]  pos_in;
      logic             zero_in;
      logic [WIDTH-1:0] rem_in;
`ifdef LEADING_ONE_PIPE_NORM_EN
      logic [WIDTH-1:0] norm_in;
`endif

      if (gi == 0) begin : g_src
        assign v_in      = in_valid;
        assign onehot_in = det_onehot;
        assign pos_in    = det_pos;
        assign zero_in   = det_zero;
        assign rem_in    = det_rem;
`ifdef LEADING_ONE_PIPE_NORM_EN
        assign norm_in   = det_norm;
`endif
      end else begin : g_src
        assign v_in      = g_stage[gi-1].v_reg;
        assign onehot_in = g_stage[gi-1].onehot_reg;
        assign pos_in    = g_stage[gi-1].pos_reg;
        assign zero_in   = g_stage[gi-1].zero_reg;
        assign rem_in    = g_stage[gi-1].rem_reg;
`ifdef LEADING_ONE_PIPE_NORM_EN
        assign norm_in   = g_stage[gi-1].norm_reg;
`endif
      end

      assign v_vec[gi] = v_reg;
      assign en[gi]    = out_ready | ~(&v_vec[STAGES-1:gi]);

      // Stage register: valid follows the source whenever enabled; payload
      // only updates on a real word so idle cycles leave it untouched.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_reg      <= 1'b0;
          onehot_reg <= '0;
          pos_reg    <= '0;
          zero_reg   <= 1'b0;
          rem_reg    <= '0;
`ifdef LEADING_ONE_PIPE_NORM_EN
          norm_reg   <= '0;
`endif
        end else if (en[gi]) begin
          v_reg <= v_in;
          if (v_in) begin
            onehot_reg <= onehot_in;
            pos_reg    <= pos_in;
            zero_reg   <= zero_in;
            rem_reg    <= rem_in;
`ifdef LEADING_ONE_PIPE_NORM_EN
            norm_reg   <= norm_in;
`endif
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Ports
  // ---------------------------------------------------------------------------
  assign in_ready   = en[0];
  assign out_valid  = g_stage[STAGES-1].v_reg;
  assign out_onehot = g_stage[STAGES-1].onehot_reg;
  assign out_pos    = g_stage[STAGES-1].pos_reg;
  assign out_zero   = g_stage[STAGES-1].zero_reg;
  assign out_rem    = g_stage[STAGES-1].rem_reg;
`ifdef LEADING_ONE_PIPE_NORM_EN
  assign out_norm   = g_stage[STAGES-1].norm_reg;
`endif

endmodule

// File: doc/leading_one_pipe.md
Name: leading_one_pipe

Overview:
Parametrised, pipelined leading-one detector with valid/ready flow control. It is the next generation of the 16-bit combinational leading-one-bit block. Per input word it produces:
- the one-hot leading-one mask
- its binary position
- a zero flag
- the residual word with the leading one cleared

It sits in front of the LOBA approximate multiplier datapath and feeds its operand-truncation and shift logic.

Parameters:
WIDTH, 16, input word width in bits; legal range 2..64.
STAGES, 2, number of register stages from input to output (latency); legal range 1..4.
(derived localparam POSW = $clog2(WIDTH), not overridable)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block accepts in_data this cycle
in_data  input  WIDTH  word to analyse
out_valid  output  1  output fields are valid
out_ready  input  1  downstream accepts output this cycle
out_onehot  output  WIDTH  one-hot mask of highest set bit of the word; 0 if word is zero
out_pos  output  POSW  index of highest set bit; 0 if word is zero
out_zero  output  1  1 when the word is all zeros
out_rem  output  WIDTH  word with leading one cleared (word XOR out_onehot)

Behaviour:
- Clock and reset: one clock (clk); synchronous, active-high reset (rst).
- Detection:
  - Computed combinationally from in_data and captured in stage 0.
  - Stages 1..STAGES-1 are pure delay registers carrying all fields plus a valid bit.
  - The last stage drives the out_* ports directly (registered outputs).
- Priority: bit WIDTH-1 has highest priority; the result is exactly the single highest set bit.
- Stage enables, with v[k] the stage-k valid bit:
  - en[STAGES-1] = !v[STAGES-1] | out_ready
  - en[k] = !v[k] | en[k+1]
  - in_ready = en[0]
  - The ready chain is combinational; no bubbles are inserted.
- On en[k]:
  - Stage k loads from stage k-1; stage 0 loads from the input.
  - v[0] <= in_valid; v[k] <= v[k-1].
  - Payload registers load only when the incoming valid is 1; otherwise they hold.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_valid = v[STAGES-1].
- Latency and throughput:
  - A word accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles after presentation, when there is no stall.
  - Full throughput is one word per cycle.
- Stall:
  - While out_valid=1 and out_ready=0, all out_* fields are held stable.
  - Bubbles in upstream stages still collapse.
  - in_ready=0 only when every stage is valid and out_ready=0.
  - Capacity is STAGES words.
  - Order is preserved; no word is dropped or duplicated.
- Simultaneous events: when the pipe is full and out_ready=1, an output transfer and an input transfer occur in the same cycle.
- Zero word: out_zero=1, out_onehot=0, out_pos=0, out_rem=0.
- Reset:
  - All v[k] are cleared, so out_valid=0 and in_ready=1 (combinationally, during and after rst).
  - All payload registers are cleared, so out_onehot, out_pos, out_rem = 0 and out_zero = 0.
  - Reset mid-operation discards all in-flight words. The first word after rst deasserts is the first output.
- in_data is don't-care when in_valid=0.

Optional Feature:
Macro LEADING_ONE_PIPE_NORM_EN.
- Defined:
  - Adds output port out_norm (WIDTH bits) = in_data shifted left by (WIDTH-1-pos), so the leading one lands at bit WIDTH-1; 0 for a zero word.
  - out_norm is computed in stage 0 and travels with the other fields: same latency, hold and reset rules (reset value 0).
- Not defined: port out_norm and its logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=16, STAGES=2, out_ready=1, in_data=16'h0000 -> out_valid=1 two cycles later; out_zero=1, out_onehot=16'h0000, out_pos=0, out_rem=16'h0000.
2. in_data=16'h8001 -> out_onehot=16'h8000, out_pos=15, out_rem=16'h0001, out_zero=0. Then in_data=16'h0013 -> out_onehot=16'h0010, out_pos=4, out_rem=16'h0003; with NORM_EN, out_norm=16'h9800.
3. Sweep all 16 single-bit words plus 16'hFFFF, back-to-back one per cycle -> outputs match a reference model in order, one result per cycle, latency 2.
4. Backpressure: stream A=16'h0100, B=16'h0002, C=16'h4000, D=16'h0001 with out_ready=0 for 5 cycles -> in_ready drops after A and B are held; A is held stable on the outputs. On out_ready=1, outputs are A, B, C, D in order, none lost.
5. Reset mid-stream: two words in flight, assert rst one cycle -> out_valid=0, in_ready=1, all outputs 0. The next accepted word 16'h0020 yields out_pos=5 as the first output.
6. Parameter sweep WIDTH=5, STAGES=1 and WIDTH=33, STAGES=4 -> in_data=5'b00110 gives out_pos=2 after 1 cycle; in_data=33'h1_0000_0000 gives out_pos=32 after 4 cycles.
